store_write_buffer: RTL and testbench
=====================================

# store_write_buffer

Write-combining FIFO between the store committer and the DCache write port. Committed store blocks (line address, line data, byte enables) are enqueued in order, merged into the youngest pending entry when they hit the same cacheable line, and drained to the DCache one line per `dcWriteReq`/`dcWriteReqAck` handshake. A combinational probe port returns buffered bytes so younger loads observe stores not yet written to the cache.

## Interface
- `ENTRY_NUM`, 4: buffer depth, power of two, at least 2.
- `ADDR_WIDTH`, 32: physical byte address width.
- `LINE_BYTE_NUM`, 16: DCache line size in bytes, power of two.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `enqValid`  in  1  committed store block present.
- `enqReady`  out  1  buffer can accept; enqueue fires when `enqValid && enqReady`.
- `enqAddr`  in  ADDR_WIDTH  byte address; low log2(LINE_BYTE_NUM) bits ignored.
- `enqData`  in  LINE_BYTE_NUM*8  line-aligned store data.
- `enqByteWE`  in  LINE_BYTE_NUM  byte enables.
- `enqUncachable`  in  1  uncachable store.
- `dcWriteReq`  out  1  head entry offered to the DCache.
- `dcWriteReqAck`  in  1  DCache accepted the head this cycle.
- `dcWriteAddr`  out  ADDR_WIDTH  head line address, low bits zero.
- `dcWriteData`  out  LINE_BYTE_NUM*8  head data.
- `dcWriteByteWE`  out  LINE_BYTE_NUM  head byte enables.
- `dcWriteUncachable`  out  1  head uncachable flag.
- `loadProbeAddr`  in  ADDR_WIDTH  load address to search.
- `loadProbeByteValid`  out  LINE_BYTE_NUM  buffered byte present per byte lane.
- `loadProbeData`  out  LINE_BYTE_NUM*8  youngest buffered value per byte.
- `loadProbeHit`  out  1  OR of `loadProbeByteValid`.
- `empty`  out  1  count == 0.
- `count`  out  log2(ENTRY_NUM)+1  occupied entries.

## Operation
- Circular buffer with head/tail pointers of log2(ENTRY_NUM) bits that wrap modulo ENTRY_NUM, plus a count register. Each entry stores line address, data, byte enables, and the uncachable flag.
- `enqReady` = (count != ENTRY_NUM). It does not depend on mergeability.
- Merge condition: count >= 2, and the youngest entry (tail-1) has the same line address, and neither that entry nor the incoming store is uncachable.
  - On merge, bytes with `enqByteWE` set overwrite the entry's data, and the entry's byte enables become old OR new.
  - Tail and count are unchanged.
- The head entry is never a merge target (count == 1 forbids merging), because the head is already being offered to the DCache.
- On a non-merge enqueue, the store is written at tail; tail increments and count increments.
- Drain: `dcWriteReq` = !empty. The `dcWrite*` outputs are driven from the head entry, and are all zero when empty. When `dcWriteReqAck && dcWriteReq`, the head is invalidated and head increments. `dcWriteReqAck` while empty is ignored.
- Simultaneous pop and allocate: count is unchanged and both pointers advance.
- Simultaneous pop and merge at count == 2: the merge lands in the new head before it is offered. This is legal because the merge target was not the offered entry.
- Probe (combinational):
  - Every valid entry whose line address matches `loadProbeAddr` contributes its enabled bytes.
  - For each byte, the youngest contributing entry wins.
  - Uncachable entries participate.
- Entries drain strictly in FIFO order, so store ordering to memory is preserved.

## Timing
- Reset (asynchronous assert, synchronous release at the `clk` edge):
  - head, tail and count are 0 and all entry valid bits are cleared.
  - Outputs: `dcWriteReq` 0, `dcWrite*` 0, `enqReady` 1, `empty` 1, `count` 0, probe outputs 0.
- A reset asserted mid-operation discards all buffered stores, including a head offered without ack.
- An enqueue at edge N is visible on the probe and on `count` after edge N.
- For an empty buffer, `dcWriteReq` rises in the cycle after the enqueue edge.
- An ack at edge M removes the head. The next entry is offered in cycle M+1, giving one line per cycle at full throughput.
- `dcWrite*` stay stable while `dcWriteReq` is high and no ack is given.
- When full, `enqReady` rises in the cycle after the popping edge (registered count). There is no same-cycle pop-to-enqueue bypass.

## Test plan
- Reset, then enqueue A=0x100 with data bytes 0..15=0x11 and WE=0xFFFF; hold ack low. Expected: `dcWriteReq`=1, `dcWriteAddr`=0x100, `count`=1. Ack one cycle later gives `empty`=1.
- With ack held low, enqueue 0x100 (WE 0x000F, data 0xAA), 0x200 (WE 0x00FF), then 0x200 again (WE 0xFF00). Expected: `count`=2 (merged), second entry WE=0xFFFF, head still 0x100 with WE 0x000F.
- Fill 4 entries at distinct lines with ack low. Expected: `enqReady`=0. A 5th `enqValid` is not accepted. After one ack, `enqReady`=1 next cycle, and wraparound ordering is verified across 8 pushes/pops.
- Enqueue an uncachable store to 0x300 twice. Expected: `count`=2 (no merge), each entry drains separately with `dcWriteUncachable`=1.
- Buffer 0x400 byte 0=0x11 then 0x400 byte 0=0x22 (second stored as a separate entry because count was 1). Probe 0x404. Expected: `loadProbeByteValid`=0x0001, byte 0 = 0x22, `loadProbeHit`=1.
- Same-cycle enqueue and ack at count 2: count stays 2 and pointers advance. Assert `rst` mid-drain: `dcWriteReq` drops immediately and `empty`=1.

Source files
------------

// File: rtl/store_write_buffer.sv
// Write-combining store buffer between the store committer and the DCache write port.
// Merges into the youngest non-head cacheable entry and exposes a youngest-wins load probe.
module store_write_buffer #(
  parameter int unsigned ENTRY_NUM     = 4,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned LINE_BYTE_NUM = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enqValid,
  output logic                            enqReady,
  input  logic [ADDR_WIDTH-1:0]           enqAddr,
  input  logic [LINE_BYTE_NUM*8-1:0]      enqData,
  input  logic [LINE_BYTE_NUM-1:0]        enqByteWE,
  input  logic                            enqUncachable,
  output logic                            dcWriteReq,
  input  logic                            dcWriteReqAck,
  output logic [ADDR_WIDTH-1:0]           dcWriteAddr,
  output logic [LINE_BYTE_NUM*8-1:0]      dcWriteData,
  output logic [LINE_BYTE_NUM-1:0]        dcWriteByteWE,
  output logic                            dcWriteUncachable,
  input  logic [ADDR_WIDTH-1:0]           loadProbeAddr,
  output logic [LINE_BYTE_NUM-1:0]        loadProbeByteValid,
  output logic [LINE_BYTE_NUM*8-1:0]      loadProbeData,
  output logic                            loadProbeHit,
  output logic                            empty,
  output logic [$clog2(ENTRY_NUM):0]      count
);

  localparam int unsigned PW = $clog2(ENTRY_NUM);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = $clog2(LINE_BYTE_NUM);
  localparam int unsigned LW = ADDR_WIDTH - OW;
  localparam int unsigned DW = LINE_BYTE_NUM * 8;

  logic [LW-1:0]            e_line  [ENTRY_NUM];
  logic [DW-1:0]            e_data  [ENTRY_NUM];
  logic [LINE_BYTE_NUM-1:0] e_we    [ENTRY_NUM];
  logic                     e_unc   [ENTRY_NUM];
  logic                     e_valid [ENTRY_NUM];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] youngest;
  logic [PW-1:0] probe_idx;
  logic [LW-1:0] enq_line;
  logic [LW-1:0] probe_line;
  logic          fire;
  logic          pop;
  logic          merge;
  logic          alloc;

  assign enq_line   = enqAddr[ADDR_WIDTH-1:OW];
  assign probe_line = loadProbeAddr[ADDR_WIDTH-1:OW];
  assign youngest   = tail - PW'(1);
  assign empty      = (count == CW'(0));
  assign enqReady   = (count != CW'(ENTRY_NUM));
  assign dcWriteReq = !empty;
  assign fire       = enqValid && enqReady;
  assign pop        = dcWriteReqAck && !empty;
  // count >= 2 keeps the offered head out of reach of merging
  assign merge      = fire && (count >= CW'(2)) && (e_line[youngest] == enq_line)
                      && !e_unc[youngest] && !enqUncachable;
  assign alloc      = fire && !merge;

  assign dcWriteAddr       = empty ? '0 : {e_line[head], OW'(0)};
  assign dcWriteData       = empty ? '0 : e_data[head];
  assign dcWriteByteWE     = empty ? '0 : e_we[head];
  assign dcWriteUncachable = empty ? 1'b0 : e_unc[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
        e_line[i]  <= '0;
        e_data[i]  <= '0;
        e_we[i]    <= '0;
        e_unc[i]   <= 1'b0;
        e_valid[i] <= 1'b0;
      end
    end else begin
      if (pop) begin
        e_valid[head] <= 1'b0;
        head          <= head + PW'(1);
      end
      if (alloc) begin
        e_line[tail]  <= enq_line;
        e_data[tail]  <= enqData;
        e_we[tail]    <= enqByteWE;
        e_unc[tail]   <= enqUncachable;
        e_valid[tail] <= 1'b1;
        tail          <= tail + PW'(1);
      end
      if (merge) begin
        for (int b = 0; b < LINE_BYTE_NUM; b++) begin
          if (enqByteWE[b]) e_data[youngest][b*8 +: 8] <= enqData[b*8 +: 8];
        end
        e_we[youngest] <= e_we[youngest] | enqByteWE;
      end
      count <= count + CW'(alloc) - CW'(pop);
    end
  end

  // Walk oldest to youngest so younger entries overwrite older bytes.
  always_comb begin
    loadProbeByteValid = '0;
    loadProbeData      = '0;
    probe_idx          = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      probe_idx = head + PW'(i);
      if (e_valid[probe_idx] && (e_line[probe_idx] == probe_line)) begin
        for (int b = 0; b < LINE_BYTE_NUM; b++) begin
          if (e_we[probe_idx][b]) begin
            loadProbeByteValid[b]    = 1'b1;
            loadProbeData[b*8 +: 8]  = e_data[probe_idx][b*8 +: 8];
          end
        end
      end
    end
  end

  assign loadProbeHit = |loadProbeByteValid;

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_store_write_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         enqValid;
  logic         enqReady;
  logic [31:0]  enqAddr;
  logic [127:0] enqData;
  logic [15:0]  enqByteWE;
  logic         enqUncachable;
  logic         dcWriteReq;
  logic         dcWriteReqAck;
  logic [31:0]  dcWriteAddr;
  logic [127:0] dcWriteData;
  logic [15:0]  dcWriteByteWE;
  logic         dcWriteUncachable;
  logic [31:0]  loadProbeAddr;
  logic [15:0]  loadProbeByteValid;
  logic [127:0] loadProbeData;
  logic         loadProbeHit;
  logic         empty;
  logic [2:0]   count;

  always #5 clk = ~clk;

  store_write_buffer #(.ENTRY_NUM(4), .ADDR_WIDTH(32), .LINE_BYTE_NUM(16)) dut (
    .clk(clk), .rst(rst),
    .enqValid(enqValid), .enqReady(enqReady), .enqAddr(enqAddr), .enqData(enqData),
    .enqByteWE(enqByteWE), .enqUncachable(enqUncachable),
    .dcWriteReq(dcWriteReq), .dcWriteReqAck(dcWriteReqAck), .dcWriteAddr(dcWriteAddr),
    .dcWriteData(dcWriteData), .dcWriteByteWE(dcWriteByteWE),
    .dcWriteUncachable(dcWriteUncachable),
    .loadProbeAddr(loadProbeAddr), .loadProbeByteValid(loadProbeByteValid),
    .loadProbeData(loadProbeData), .loadProbeHit(loadProbeHit),
    .empty(empty), .count(count)
  );

  typedef struct packed {
    logic [27:0]  line;
    logic [127:0] data;
    logic [15:0]  we;
    logic         unc;
  } ent_t;

  ent_t mq[$];
  int   vecs = 0;
  int   errs = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model state and current probe address.
  task automatic check_all();
    logic [15:0]  pv;
    logic [127:0] pd;
    pv = '0;
    pd = '0;
    foreach (mq[i]) begin
      if (mq[i].line == loadProbeAddr[31:4]) begin
        for (int b = 0; b < 16; b++) begin
          if (mq[i].we[b]) begin
            pv[b] = 1'b1;
            pd[b*8 +: 8] = mq[i].data[b*8 +: 8];
          end
        end
      end
    end
    chk("count", 128'(count), 128'(mq.size()));
    chk("empty", 128'(empty), 128'(mq.size() == 0));
    chk("enqReady", 128'(enqReady), 128'(mq.size() != 4));
    chk("dcWriteReq", 128'(dcWriteReq), 128'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("dcWriteAddr", 128'(dcWriteAddr), 128'({mq[0].line, 4'h0}));
      chk("dcWriteData", dcWriteData, mq[0].data);
      chk("dcWriteByteWE", 128'(dcWriteByteWE), 128'(mq[0].we));
      chk("dcWriteUncachable", 128'(dcWriteUncachable), 128'(mq[0].unc));
    end else begin
      chk("dcWrite_idle", {dcWriteData[126:0], dcWriteUncachable},
          128'({dcWriteAddr, dcWriteByteWE}));
    end
    chk("probeValid", 128'(loadProbeByteValid), 128'(pv));
    chk("probeData", loadProbeData, pd);
    chk("probeHit", 128'(loadProbeHit), 128'(pv != 16'h0));
  endtask

  // Reference behaviour: FIFO queue with merge into the youngest cacheable entry when size >= 2.
  task automatic model_update();
    bit   fire, pop, mrg;
    ent_t e;
    fire = enqValid && (mq.size() != 4);
    pop  = dcWriteReqAck && (mq.size() != 0);
    mrg  = 1'b0;
    if (fire && mq.size() >= 2)
      mrg = (mq[$].line == enqAddr[31:4]) && !mq[$].unc && !enqUncachable;
    if (mrg) begin
      e = mq[$];
      for (int b = 0; b < 16; b++)
        if (enqByteWE[b]) e.data[b*8 +: 8] = enqData[b*8 +: 8];
      e.we = e.we | enqByteWE;
      mq[mq.size()-1] = e;
    end
    if (pop) mq.delete(0);
    if (fire && !mrg) mq.push_back('{enqAddr[31:4], enqData, enqByteWE, enqUncachable});
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [127:0] d,
                       input logic [15:0] we, input logic unc, input logic ack);
    enqValid      = v;
    enqAddr       = a;
    enqData       = d;
    enqByteWE     = we;
    enqUncachable = unc;
    dcWriteReqAck = ack;
  endtask

  task automatic step();
    #1;
    check_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && mq.size() != 0; k++) begin
      drive(1'b0, 32'h0, 128'h0, 16'h0, 1'b0, 1'b1);
      step();
    end
    drive(1'b0, 32'h0, 128'h0, 16'h0, 1'b0, 1'b0);
    chk("drained", 128'(empty), 128'(1));
  endtask

  function automatic logic [127:0] rdata();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst = 1'b1;
    loadProbeAddr = 32'h100;
    drive(1'b0, 32'h0, 128'h0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Single enqueue offered, then acked
    drive(1'b1, 32'h100, {16{8'h11}}, 16'hFFFF, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 128'h0, 16'h0, 1'b0, 1'b0);
    chk("t1_req", 128'(dcWriteReq), 128'(1));
    chk("t1_addr", 128'(dcWriteAddr), 128'(32'h100));
    chk("t1_count", 128'(count), 128'(1));
    drive(1'b0, 32'h0, 128'h0, 16'h0, 1'b0, 1'b1);
    step();
    chk("t1_empty", 128'(empty), 128'(1));

    // Merge into youngest, never into head
    drive(1'b1, 32'h100, {16{8'hAA}}, 16'h000F, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h200, rdata(), 16'h00FF, 1'b0, 1'b0);
    step();
    loadProbeAddr = 32'h208;
    drive(1'b1, 32'h200, rdata(), 16'hFF00, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 128'h0, 16'h0, 1'b0, 1'b0);
    chk("t2_count", 128'(count), 128'(2));
    chk("t2_headaddr", 128'(dcWriteAddr), 128'(32'h100));
    chk("t2_headwe", 128'(dcWriteByteWE), 128'(16'h000F));
    chk("t2_mergedwe", 128'(loadProbeByteValid), 128'(16'hFFFF));
    drain();

    // Fill, back-pressure, wraparound
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1000 + 32'(i) * 32'h10, rdata(), 16'(i + 1), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h2000, rdata(), 16'hFFFF, 1'b0, 1'b0);
    step();
    chk("t3_full", 128'(enqReady), 128'(0));
    chk("t3_count", 128'(count), 128'(4));
    drive(1'b1, 32'h2000, rdata(), 16'hFFFF, 1'b0, 1'b1);
    step();
    chk("t3_count_pop", 128'(count), 128'(3));
    chk("t3_ready", 128'(enqReady), 128'(1));
    for (int i = 0; i < 8; i++) begin
      loadProbeAddr = 32'h3000 + 32'(i) * 32'h10;
      drive(1'b1, 32'h3000 + 32'(i) * 32'h10, rdata(), 16'($urandom), 1'b0, 1'b1);
      step();
    end
    drain();

    // Uncachable stores never merge
    drive(1'b1, 32'h300, rdata(), 16'hFFFF, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h300, rdata(), 16'hFFFF, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h300, rdata(), 16'hFFFF, 1'b1, 1'b0);
    step();
    chk("t4_count", 128'(count), 128'(3));
    chk("t4_unc", 128'(dcWriteUncachable), 128'(1));
    drain();

    // Probe youngest-wins across two separate entries
    loadProbeAddr = 32'h404;
    drive(1'b1, 32'h400, 128'h11, 16'h0001, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h400, 128'h22, 16'h0001, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 128'h0, 16'h0, 1'b0, 1'b0);
    chk("t5_count", 128'(count), 128'(2));
    chk("t5_valid", 128'(loadProbeByteValid), 128'(16'h0001));
    chk("t5_byte0", 128'(loadProbeData[7:0]), 128'(8'h22));
    chk("t5_hit", 128'(loadProbeHit), 128'(1));

    // Simultaneous allocate and pop at count 2, then merge-with-pop
    drive(1'b1, 32'h500, rdata(), 16'h00F0, 1'b0, 1'b1);
    step();
    chk("t6_count", 128'(count), 128'(2));
    chk("t6_head", 128'(dcWriteAddr), 128'(32'h400));
    loadProbeAddr = 32'h500;
    drive(1'b1, 32'h500, rdata(), 16'h0F00, 1'b0, 1'b1);
    step();
    chk("t6_mergepop_count", 128'(count), 128'(1));
    chk("t6_mergepop_we", 128'(dcWriteByteWE), 128'(16'h0FF0));
    drain();

    // Random traffic over a few lines
    for (int n = 0; n < 400; n++) begin
      loadProbeAddr = 32'h100 * 32'($urandom_range(1, 4)) + 32'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 3) != 0), 32'h100 * 32'($urandom_range(1, 4)), rdata(),
            16'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) == 0));
      step();
    end
    drain();

    // Reset mid-drain discards offered head
    drive(1'b1, 32'h600, rdata(), 16'hFFFF, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h700, rdata(), 16'hFFFF, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 128'h0, 16'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("t7_req", 128'(dcWriteReq), 128'(0));
    chk("t7_empty", 128'(empty), 128'(1));
    chk("t7_count", 128'(count), 128'(0));
    mq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
